// File: rtl/button_conditioner.sv
// Four-button debouncer with press/release pulses; auto-repeat presses are
// added when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 400,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       any_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_MS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS - 1);

  logic [3:0]         sync1_q, sync2_q;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         level_q, level_d;
  logic [3:0]         press_q, press_d;
  logic [3:0]         release_q, release_d;
  logic               any_q, any_d;
  logic [3:0]         rep_d;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY_MS + 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

  logic [3:0][RW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_1ms) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rep_d = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rpt_d = rpt_q;
    // Reloading to DELAY-RATE makes every later repeat land RATE ticks apart.
    for (int unsigned i = 0; i < 4; i++) begin
      if ((level_d[i] != level_q[i]) || !level_q[i]) begin
        rpt_d[i] = '0;
      end else if (tick_1ms) begin
        if (rpt_q[i] == RPT_LAST) begin
          rep_d[i] = 1'b1;
          rpt_d[i] = RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + RW'(1);
        end
      end
    end
`endif
    press_d   = (level_d & ~level_q) | rep_d;
    release_d = ~level_d & level_q;
    any_d     = |press_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_press   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE_MS=4, tick every 10 clk);
// expected pulse events are queued at stimulus time and popped when the DUT pulses.
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic       tick_1ms;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       any_press;

  typedef struct {
    int unsigned tick;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  level;
  } ev_t;

  ev_t         sb[$];
  int unsigned tick_cnt = 0;
  int          compared = 0;
  int          mismatched = 0;

  button_conditioner #(
    .DEBOUNCE_MS    (4),
    .REPEAT_DELAY_MS(8),
    .REPEAT_RATE_MS (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1ms   (tick_1ms),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int unsigned div;
    div      = 0;
    tick_1ms = 1'b0;
    forever begin
      @(negedge clk);
      tick_1ms = (div == 9);
      div      = (div == 9) ? 0 : div + 1;
    end
  end

  initial begin
    #300000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned t, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l);
    ev_t e;
    e.tick  = t;
    e.press = p;
    e.rel   = r;
    e.level = l;
    sb.push_back(e);
  endtask

  // Monitor: any pulse must match the next queued event, including its tick.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      if (tick_1ms) tick_cnt++;
      #1;
      if (btn_press != 4'b0 || btn_release != 4'b0 || any_press) begin
        compared++;
        assert (sb.size() != 0) else begin
          mismatched++;
          $error("FAIL spurious_pulse: observed press=%b release=%b any=%b at tick %0d expected none",
                 btn_press, btn_release, any_press, tick_cnt);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("event_tick", tick_cnt, e.tick);
          chk("press", {28'b0, btn_press}, {28'b0, e.press});
          chk("release", {28'b0, btn_release}, {28'b0, e.rel});
          chk("level", {28'b0, btn_level}, {28'b0, e.level});
          chk("any_press", {31'b0, any_press}, {31'b0, |e.press});
        end
      end
    end
  end

  task automatic after_tick();
    do @(posedge clk); while (!tick_1ms);
    @(negedge clk);
  endtask

  task automatic goto_tick(input int unsigned n);
    do after_tick(); while (tick_cnt < n);
  endtask

  initial begin
    int unsigned t, a;
    reset   = 1'b0;
    btn_raw = 4'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", {28'b0, btn_level}, 32'h0);
    chk("rst_press", {28'b0, btn_press}, 32'h0);
    chk("rst_release", {28'b0, btn_release}, 32'h0);
    chk("rst_any", {31'b0, any_press}, 32'h0);
    reset = 1'b1;

    // Single press on bit 0, held, then released
    after_tick();
    t = tick_cnt;
    btn_raw[0] = 1'b1;
    a = t + 4;
    push(a, 4'b0001, 4'b0000, 4'b0001);
`ifdef BUTTON_AUTO_REPEAT_EN
    push(a + 8,  4'b0001, 4'b0000, 4'b0001);
    push(a + 11, 4'b0001, 4'b0000, 4'b0001);
    push(a + 14, 4'b0001, 4'b0000, 4'b0001);
    push(a + 17, 4'b0001, 4'b0000, 4'b0001);
    push(a + 20, 4'b0001, 4'b0000, 4'b0001);
`endif
    goto_tick(a + 1);
    chk("hold_level", {28'b0, btn_level}, 32'h1);
    goto_tick(a + 17);
    btn_raw[0] = 1'b0;
    push(a + 21, 4'b0000, 4'b0001, 4'b0000);
    goto_tick(a + 24);
    chk("released_level", {28'b0, btn_level}, 32'h0);

    // Glitch on bit 2 lasting three ticks
    after_tick();
    t = tick_cnt;
    btn_raw[2] = 1'b1;
    goto_tick(t + 3);
    btn_raw[2] = 1'b0;
    goto_tick(t + 8);
    chk("glitch_level", {28'b0, btn_level}, 32'h0);

    // Bits 1 and 3 together
    after_tick();
    t = tick_cnt;
    btn_raw = 4'b1010;
    push(t + 4, 4'b1010, 4'b0000, 4'b1010);
    goto_tick(t + 4);
    btn_raw = 4'b0000;
    push(t + 8, 4'b0000, 4'b1010, 4'b0000);
    goto_tick(t + 9);
    chk("pair_level", {28'b0, btn_level}, 32'h0);

    // Reset mid-count while bit 3 is accepted and bit 0 is counting
    after_tick();
    t = tick_cnt;
    btn_raw[3] = 1'b1;
    push(t + 4, 4'b1000, 4'b0000, 4'b1000);
    goto_tick(t + 4);
    chk("b3_level", {28'b0, btn_level}, 32'h8);
    btn_raw[0] = 1'b1;
    t = tick_cnt;
    goto_tick(t + 2);
    reset = 1'b0;
    #1;
    chk("async_level", {28'b0, btn_level}, 32'h0);
    chk("async_press", {28'b0, btn_press}, 32'h0);
    chk("async_release", {28'b0, btn_release}, 32'h0);
    chk("async_any", {31'b0, any_press}, 32'h0);
    repeat (5) @(negedge clk);
    chk("inrst_level", {28'b0, btn_level}, 32'h0);
    reset = 1'b1;
    push(t + 6, 4'b1001, 4'b0000, 4'b1001);
    goto_tick(t + 6);
    btn_raw = 4'b0000;
    push(t + 10, 4'b0000, 4'b1001, 4'b0000);
    goto_tick(t + 12);
    chk("final_level", {28'b0, btn_level}, 32'h0);

    goto_tick(tick_cnt + 3);
    chk("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_MS, default 10, meaning the number of consecutive tick_1ms pulses a changed input must hold before it is accepted (legal range 2..255).
REQ-002 The block SHALL have parameter REPEAT_DELAY_MS, default 400, meaning ticks of continuous hold before the first auto-repeat press.
REQ-003 The block SHALL have parameter REPEAT_RATE_MS, default 100, meaning ticks between later auto-repeat presses.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port tick_1ms, input, 1 bit, a one-clk-wide enable pulse once per millisecond.
REQ-007 The block SHALL have port btn_raw, input, 4 bits, the asynchronous pushbuttons: bit0=button, bit1=button1, bit2=button2, bit3=button3.
REQ-008 The block SHALL have port btn_level, output, 4 bits, the debounced button state.
REQ-009 The block SHALL have port btn_press, output, 4 bits, a one-clk pulse per accepted press.
REQ-010 The block SHALL have port btn_release, output, 4 bits, a one-clk pulse per accepted release.
REQ-011 The block SHALL have port any_press, output, 1 bit, the OR of btn_press, registered in the same cycle.

Function
REQ-012 Each btn_raw bit SHALL pass through a two-flop synchronizer; only the second flop's output (sync) SHALL feed the logic.
REQ-013 Each bit SHALL have an independent counter cnt of width clog2(DEBOUNCE_MS).
REQ-014 Whenever sync equals btn_level, in any clk cycle, cnt SHALL be cleared to 0.
REQ-015 On a tick_1ms cycle where sync differs from btn_level and cnt is less than DEBOUNCE_MS-1, cnt SHALL increment by 1.
REQ-016 On a tick_1ms cycle where sync differs from btn_level and cnt equals DEBOUNCE_MS-1, btn_level SHALL take the value of sync and cnt SHALL clear, i.e. on the DEBOUNCE_MS-th differing tick.
REQ-017 A glitch shorter than the debounce window SHALL clear cnt, and btn_level SHALL NOT change.
REQ-018 btn_press[i] SHALL be high for exactly the one clk in which btn_level[i] rises from 0 to 1.
REQ-019 btn_release[i] SHALL be high for exactly the one clk in which btn_level[i] falls from 1 to 0.
REQ-020 btn_press[i] and btn_release[i] SHALL never be high in the same cycle.
REQ-021 All four bits SHALL operate independently; simultaneous acceptances on several bits SHALL all pulse in the same cycle.
REQ-022 tick_1ms held high for several consecutive clks SHALL count once per clk; the block SHALL NOT detect tick edges.
REQ-023 All outputs SHALL be registered; no combinational path SHALL run from inputs to outputs.

Reset
REQ-024 While reset=0, the synchronizer flops, cnt, the repeat counters, btn_level, btn_press, btn_release and any_press SHALL all be 0, asynchronously.
REQ-025 If reset is asserted mid-count, the count SHALL be discarded; after release, a held button SHALL require the full DEBOUNCE_MS ticks (plus 2 clk of sync) before btn_press.
REQ-026 Reset deassertion with all buttons released SHALL produce no press or release pulse.

Configuration
REQ-027 With macro BUTTON_AUTO_REPEAT_EN defined, each bit SHALL have a repeat counter that clears on any btn_level change and counts ticks while btn_level[i]=1.
REQ-028 Under BUTTON_AUTO_REPEAT_EN, btn_press[i] SHALL also pulse one clk on the tick reaching REPEAT_DELAY_MS, then every REPEAT_RATE_MS ticks while held; release SHALL stop repeats immediately.
REQ-029 With BUTTON_AUTO_REPEAT_EN undefined, the repeat logic SHALL be absent and btn_press SHALL pulse only on rising btn_level.

Verification (DEBOUNCE_MS=4, tick every 10 clk)
REQ-030 Scenario: btn_raw[0] 0->1 held -> exactly one btn_press[0] and any_press pulse on the 4th tick after sync; btn_level[0]=1 from that cycle.
REQ-031 Scenario: btn_raw[2] high for 3 ticks, then low -> btn_level, btn_press and btn_release stay 0 throughout.
REQ-032 Scenario: bits 1 and 3 pressed in the same clk -> btn_press=4'b1010 in a single cycle; btn_release=4'b1010 after both are released for 4 ticks.
REQ-033 Scenario: reset pulled low after 2 ticks of a held press, released 5 clk later -> outputs 0 during reset; press accepted on the 4th tick after re-sync.
REQ-034 Scenario: BUTTON_AUTO_REPEAT_EN defined, REPEAT_DELAY_MS=8, REPEAT_RATE_MS=3, button held 20 ticks past acceptance -> btn_press at acceptance, then at +8, +11, +14, +17 and +20 ticks; none after release.
